// File: rtl/seq_stage_ctrl_if.sv
// Data-memory handshake between the SEQ stage sequencer (master) and the
// data memory (slave).
interface seq_stage_ctrl_if;
    logic mem_req;
    logic mem_ready;
    logic dmem_error;

    modport master (
        output mem_req,
        input  mem_ready,
        input  dmem_error
    );

    modport slave (
        input  mem_req,
        output mem_ready,
        output dmem_error
    );
endinterface

// File: rtl/seq_stage_ctrl.sv
// Multi-cycle sequencer for the Y86-64 SEQ datapath: owns the PC, walks each
// instruction through F/D/E/M/W/PC-update and records halt/fault status.

module seq_stage_ctrl_chk (
    input logic       clk,
    input logic       rst,
    input logic [5:0] stage_en,
    input logic       mem_req,
    input logic       halted
);
    a_stage_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(stage_en));
    a_halt_quiet:   assert property (@(posedge clk) disable iff (rst) halted |-> (stage_en == 6'b000000));
    a_req_in_mem:   assert property (@(posedge clk) disable iff (rst) mem_req |-> (stage_en == 6'b001000));
endmodule

module seq_stage_ctrl #(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [3:0]              icode,
    input  logic                    instr_valid,
    input  logic                    imem_error,
    input  logic [63:0]             newpc,
    seq_stage_ctrl_if.master        dmem,
    output logic [63:0]             pc,
    output logic [5:0]              stage_en,
    output logic [2:0]              stat,
    output logic                    halted,
    output logic [31:0]             instr_cnt
);

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    // Waiting counter value seen on the last MEM cycle allowed before timeout.
    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_PCUPD  = 3'd6,
        S_HALTED = 3'd7
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [3:0]  icode_r;
    logic [63:0] pc_r;
    logic [2:0]  stat_r;
    logic [2:0]  stat_next_s;
    logic [31:0] instr_cnt_r;
    logic [7:0]  tmo_r;
    logic [7:0]  tmo_next_s;
    logic [5:0]  stage_en_r;
    logic        mem_req_r;
    logic        halted_r;
    logic        retire_s;
    logic        latch_icode_s;

    function automatic logic is_mem_icode(input logic [3:0] ic);
        logic r;
        case (ic)
            IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ: r = 1'b1;
            default:                                      r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [5:0] stage_decode(input state_t st);
        logic [5:0] r;
        case (st)
            S_FETCH:  r = 6'b000001;
            S_DECODE: r = 6'b000010;
            S_EXEC:   r = 6'b000100;
            S_MEM:    r = 6'b001000;
            S_WB:     r = 6'b010000;
            S_PCUPD:  r = 6'b100000;
            default:  r = 6'b000000;
        endcase
        return r;
    endfunction

    // Next-state, status and timeout decisions for the stage sequencer.
    always_comb begin
        state_next_s  = state_r;
        stat_next_s   = stat_r;
        tmo_next_s    = tmo_r;
        retire_s      = 1'b0;
        latch_icode_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_next_s = S_FETCH;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_FETCH: begin
                // Fault priority: fetch address fault, then illegal code, then halt.
                if (imem_error) begin
                    state_next_s = S_HALTED;
                    stat_next_s  = STAT_ADR;
                end else if (!instr_valid) begin
                    state_next_s = S_HALTED;
                    stat_next_s  = STAT_INS;
                end else if (icode == IHALT) begin
                    state_next_s = S_HALTED;
                    stat_next_s  = STAT_HLT;
                end else begin
                    state_next_s  = S_DECODE;
                    latch_icode_s = 1'b1;
                end
            end
            S_DECODE: state_next_s = S_EXEC;
            S_EXEC: begin
                state_next_s = S_MEM;
                tmo_next_s   = 8'd0;
            end
            S_MEM: begin
                if (is_mem_icode(icode_r)) begin
                    if (dmem.mem_ready) begin
                        if (dmem.dmem_error) begin
                            state_next_s = S_HALTED;
                            stat_next_s  = STAT_ADR;
                        end else begin
                            state_next_s = S_WB;
                        end
                    end else if (tmo_r == TMO_LAST) begin
                        state_next_s = S_HALTED;
                        stat_next_s  = STAT_ADR;
                    end else begin
                        state_next_s = S_MEM;
                        tmo_next_s   = tmo_r + 8'd1;
                    end
                end else begin
                    state_next_s = S_WB;
                end
            end
            S_WB:     state_next_s = S_PCUPD;
            S_PCUPD: begin
                state_next_s = S_FETCH;
                retire_s     = 1'b1;
            end
            S_HALTED: state_next_s = S_HALTED;
            default:  state_next_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Architectural registers and registered outputs, decoded from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r        <= RESET_PC;
            stat_r      <= STAT_AOK;
            instr_cnt_r <= 32'd0;
            icode_r     <= 4'h0;
            tmo_r       <= 8'd0;
            stage_en_r  <= 6'b000000;
            mem_req_r   <= 1'b0;
            halted_r    <= 1'b0;
        end else begin
            if (retire_s) begin
                pc_r        <= newpc;
                instr_cnt_r <= instr_cnt_r + 32'd1;
            end
            if (latch_icode_s) begin
                icode_r <= icode;
            end
            stat_r     <= stat_next_s;
            tmo_r      <= tmo_next_s;
            stage_en_r <= stage_decode(state_next_s);
            mem_req_r  <= (state_next_s == S_MEM) && is_mem_icode(icode_r);
            halted_r   <= (state_next_s == S_HALTED);
        end
    end

    assign pc           = pc_r;
    assign stage_en     = stage_en_r;
    assign stat         = stat_r;
    assign halted       = halted_r;
    assign instr_cnt    = instr_cnt_r;
    assign dmem.mem_req = mem_req_r;

    seq_stage_ctrl_chk u_chk (
        .clk      (clk),
        .rst      (rst),
        .stage_en (stage_en_r),
        .mem_req  (mem_req_r),
        .halted   (halted_r)
    );

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Self-checking bench for seq_stage_ctrl: per-cycle expectations are queued as
// stimulus is planned, then popped and compared while the plan is applied.
module tb_seq_stage_ctrl;

    localparam int          TMO   = 15;
    localparam logic [63:0] RSTPC = 64'h0;
    localparam logic [63:0] JUNK  = 64'hBAD0_BAD0_BAD0_BAD0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  icode = 4'h1;
    logic        instr_valid = 1'b1;
    logic        imem_error = 1'b0;
    logic [63:0] newpc = 64'h0;
    logic [63:0] pc;
    logic [5:0]  stage_en;
    logic [2:0]  stat;
    logic        halted;
    logic [31:0] instr_cnt;

    seq_stage_ctrl_if dmem_bus ();

    seq_stage_ctrl #(.RESET_PC(RSTPC), .MEM_TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .icode       (icode),
        .instr_valid (instr_valid),
        .imem_error  (imem_error),
        .newpc       (newpc),
        .dmem        (dmem_bus.master),
        .pc          (pc),
        .stage_en    (stage_en),
        .stat        (stat),
        .halted      (halted),
        .instr_cnt   (instr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        start;
        logic [3:0]  icode;
        logic        iv;
        logic        ie;
        logic [63:0] newpc;
        logic        rdy;
        logic        derr;
        logic        chk;
        logic [5:0]  se;
        logic        mreq;
        logic [2:0]  st;
        logic        hlt;
        logic [63:0] pc;
        logic [31:0] cnt;
    } cyc_t;

    typedef struct {
        logic [3:0]  ic;
        logic        iv;
        logic        ie;
        int          k;
        logic        derr;
        logic [63:0] np;
        logic [2:0]  exp_stat;
        logic [31:0] exp_cnt;
    } scen_t;

    cyc_t        sb[$];
    scen_t       tbl[10];
    int          checks = 0;
    int          errors = 0;
    int          cyc_no = 0;
    string       tag;
    logic [63:0] m_pc;
    logic [31:0] m_cnt;
    logic [2:0]  m_stat;
    logic        m_halt;

    function automatic logic mem_icode(input logic [3:0] ic);
        return (ic == 4'h4) || (ic == 4'h5) || (ic == 4'h8) ||
               (ic == 4'h9) || (ic == 4'hA) || (ic == 4'hB);
    endfunction

    task automatic push(input logic r, input logic s, input logic [3:0] ic, input logic iv,
                        input logic ie, input logic [63:0] np, input logic rdy, input logic derr,
                        input logic chk, input logic [5:0] se, input logic mreq);
        cyc_t c;
        c.rst = r; c.start = s; c.icode = ic; c.iv = iv; c.ie = ie; c.newpc = np;
        c.rdy = rdy; c.derr = derr; c.chk = chk; c.se = se; c.mreq = mreq;
        c.st = m_stat; c.hlt = m_halt; c.pc = m_pc; c.cnt = m_cnt;
        sb.push_back(c);
    endtask

    task automatic gen_reset();
        push(1'b1, 1'b0, 4'h1, 1'b1, 1'b0, JUNK, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
        m_pc = RSTPC; m_cnt = 32'd0; m_stat = 3'd1; m_halt = 1'b0;
    endtask

    task automatic gen_wait(input int n, input logic s);
        for (int i = 0; i < n; i++)
            push(1'b0, s, 4'h1, 1'b1, 1'b0, JUNK, 1'b1, 1'b1, 1'b1, 6'd0, 1'b0);
    endtask

    task automatic gen_start();
        push(1'b0, 1'b1, 4'h0, 1'b0, 1'b1, JUNK, 1'b0, 1'b0, 1'b1, 6'd0, 1'b0);
    endtask

    // One instruction from FETCH; inputs outside their sampling stage carry junk.
    task automatic gen_instr(input logic [3:0] ic, input logic iv, input logic ie,
                             input int k, input logic derr, input logic [63:0] np);
        push(1'b0, 1'b0, ic, iv, ie, JUNK, 1'b1, 1'b1, 1'b1, 6'b000001, 1'b0);
        if (ie) begin m_stat = 3'd3; m_halt = 1'b1; return; end
        if (!iv) begin m_stat = 3'd4; m_halt = 1'b1; return; end
        if (ic == 4'h0) begin m_stat = 3'd2; m_halt = 1'b1; return; end
        push(1'b0, 1'b1, 4'h0, 1'b0, 1'b1, JUNK, 1'b1, 1'b1, 1'b1, 6'b000010, 1'b0);
        push(1'b0, 1'b1, 4'h0, 1'b0, 1'b1, JUNK, 1'b1, 1'b1, 1'b1, 6'b000100, 1'b0);
        if (mem_icode(ic)) begin
            for (int j = 0; j < TMO; j++) begin
                push(1'b0, 1'b1, 4'h0, 1'b0, 1'b1, JUNK, (j == k), (j == k) ? derr : 1'b1,
                     1'b1, 6'b001000, 1'b1);
                if (j == k) begin
                    if (derr) begin m_stat = 3'd3; m_halt = 1'b1; return; end
                    break;
                end
                if (j == TMO - 1) begin m_stat = 3'd3; m_halt = 1'b1; return; end
            end
        end else begin
            push(1'b0, 1'b1, 4'h0, 1'b0, 1'b1, JUNK, 1'b1, 1'b1, 1'b1, 6'b001000, 1'b0);
        end
        push(1'b0, 1'b1, 4'h0, 1'b0, 1'b1, JUNK, 1'b1, 1'b1, 1'b1, 6'b010000, 1'b0);
        push(1'b0, 1'b1, 4'h0, 1'b0, 1'b1, np,   1'b1, 1'b1, 1'b1, 6'b100000, 1'b0);
        m_pc = np; m_cnt = m_cnt + 32'd1;
    endtask

    task automatic run_queue();
        cyc_t c;
        while (sb.size() > 0) begin
            c = sb.pop_front();
            @(negedge clk);
            cyc_no++;
            if (c.chk) begin
                checks++;
                if (stage_en !== c.se || dmem_bus.mem_req !== c.mreq || stat !== c.st ||
                    halted !== c.hlt || pc !== c.pc || instr_cnt !== c.cnt) begin
                    errors++;
                    $display("FAIL %s cyc%0d: got se=%b mreq=%b stat=%0d halt=%b pc=%h cnt=%0d, expected se=%b mreq=%b stat=%0d halt=%b pc=%h cnt=%0d",
                             tag, cyc_no, stage_en, dmem_bus.mem_req, stat, halted, pc, instr_cnt,
                             c.se, c.mreq, c.st, c.hlt, c.pc, c.cnt);
                end
            end
            rst = c.rst; start = c.start; icode = c.icode; instr_valid = c.iv;
            imem_error = c.ie; newpc = c.newpc;
            dmem_bus.mem_ready = c.rdy; dmem_bus.dmem_error = c.derr;
        end
    endtask

    task automatic check_final(input string nm, input logic [2:0] es, input logic [31:0] ec,
                               input logic eh);
        @(negedge clk);
        checks++;
        if (stat !== es || instr_cnt !== ec || halted !== eh) begin
            errors++;
            $display("FAIL %s final: got stat=%0d cnt=%0d halt=%b, expected stat=%0d cnt=%0d halt=%b",
                     nm, stat, instr_cnt, halted, es, ec, eh);
        end
    endtask

    initial begin
        dmem_bus.mem_ready  = 1'b0;
        dmem_bus.dmem_error = 1'b0;
        m_pc = RSTPC; m_cnt = 32'd0; m_stat = 3'd1; m_halt = 1'b0;

        tbl[0] = '{4'h5, 1'b1, 1'b0, 3,   1'b0, 64'h40,   3'd2, 32'd1};
        tbl[1] = '{4'hA, 1'b1, 1'b0, 255, 1'b0, 64'h99,   3'd3, 32'd0};
        tbl[2] = '{4'h1, 1'b0, 1'b1, 0,   1'b0, 64'h0,    3'd3, 32'd0};
        tbl[3] = '{4'h1, 1'b0, 1'b0, 0,   1'b0, 64'h0,    3'd4, 32'd0};
        tbl[4] = '{4'h0, 1'b1, 1'b0, 0,   1'b0, 64'h0,    3'd2, 32'd0};
        tbl[5] = '{4'h9, 1'b1, 1'b0, 0,   1'b1, 64'h77,   3'd3, 32'd0};
        tbl[6] = '{4'h8, 1'b1, 1'b0, 14,  1'b0, 64'h1234, 3'd2, 32'd1};
        tbl[7] = '{4'h6, 1'b1, 1'b0, 0,   1'b0, 64'h20,   3'd2, 32'd1};
        tbl[8] = '{4'h4, 1'b1, 1'b0, 0,   1'b0, 64'h8,    3'd2, 32'd1};
        tbl[9] = '{4'hB, 1'b1, 1'b0, 1,   1'b0, 64'h18,   3'd2, 32'd1};

        // Three NOPs, newpc = pc + 1, then a halt; later starts are ignored.
        tag = "nop3";
        gen_reset(); gen_wait(2, 1'b0); gen_start();
        for (int i = 0; i < 3; i++) gen_instr(4'h1, 1'b1, 1'b0, 0, 1'b0, m_pc + 64'd1);
        gen_instr(4'h0, 1'b1, 1'b0, 0, 1'b0, 64'h0);
        gen_wait(3, 1'b1);
        run_queue();
        @(negedge clk);
        checks++;
        if (pc !== 64'd3 || instr_cnt !== 32'd3) begin
            errors++;
            $display("FAIL nop3 end: got pc=%h cnt=%0d, expected pc=3 cnt=3", pc, instr_cnt);
        end

        for (int s = 0; s < 10; s++) begin
            tag = $sformatf("tbl%0d", s);
            gen_reset(); gen_wait(1, 1'b0); gen_start();
            gen_instr(tbl[s].ic, tbl[s].iv, tbl[s].ie, tbl[s].k, tbl[s].derr, tbl[s].np);
            if (!m_halt) gen_instr(4'h0, 1'b1, 1'b0, 0, 1'b0, 64'h0);
            gen_wait(3, 1'b1);
            run_queue();
            check_final(tag, tbl[s].exp_stat, tbl[s].exp_cnt, 1'b1);
        end

        // Reset while waiting in MEM with mem_req high.
        tag = "rst_mem";
        gen_reset(); gen_start();
        gen_instr(4'h1, 1'b1, 1'b0, 0, 1'b0, 64'h100);
        push(1'b0, 1'b0, 4'h5, 1'b1, 1'b0, JUNK, 1'b0, 1'b0, 1'b1, 6'b000001, 1'b0);
        push(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, JUNK, 1'b0, 1'b0, 1'b1, 6'b000010, 1'b0);
        push(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, JUNK, 1'b0, 1'b0, 1'b1, 6'b000100, 1'b0);
        push(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, JUNK, 1'b0, 1'b0, 1'b1, 6'b001000, 1'b1);
        push(1'b1, 1'b0, 4'h0, 1'b1, 1'b0, JUNK, 1'b0, 1'b0, 1'b1, 6'b001000, 1'b1);
        m_pc = RSTPC; m_cnt = 32'd0; m_stat = 3'd1; m_halt = 1'b0;
        gen_wait(2, 1'b0);
        gen_start();
        gen_instr(4'h0, 1'b1, 1'b0, 0, 1'b0, 64'h0);
        gen_wait(2, 1'b0);
        run_queue();
        check_final(tag, 3'd2, 32'd0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
